// File: rtl/stream_max_finder_pkg.sv
// Shared helpers for the stream min/max finder slice.
package stream_max_finder_pkg;

  // Index outputs need at least one bit even for single-sample frames.
  function automatic int idx_width(input int frame_len);
    return (frame_len > 1) ? $clog2(frame_len) : 1;
  endfunction

endpackage

// File: rtl/N_bit_comp.sv
// Unsigned N-bit magnitude comparator: A vs B, purely combinational.
module N_bit_comp #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         gt,
  output logic         eq,
  output logic         ls
);

  assign gt = (A > B);
  assign eq = (A == B);
  assign ls = (A < B);

endmodule

// File: rtl/stream_max_finder.sv
// Per-frame min/max with first-occurrence index; result valid 1 cycle after last sample accept.
// Holds the result (in_ready low) until out_ready; clear aborts the frame and drops a same-cycle sample.
module stream_max_finder
  import stream_max_finder_pkg::*;
#(
  parameter  int N         = 8,
  parameter  int FRAME_LEN = 8,
  localparam int IDX_W     = idx_width(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_max,
  output logic [N-1:0]     out_min,
  output logic [IDX_W-1:0] out_max_idx,
  output logic [IDX_W-1:0] out_min_idx
);

  localparam logic             COLLECT  = 1'b0;
  localparam logic             HOLD     = 1'b1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic             state_q;
  logic [IDX_W-1:0] count_q;
  logic [N-1:0]     max_q;
  logic [N-1:0]     min_q;
  logic [IDX_W-1:0] max_idx_q;
  logic [IDX_W-1:0] min_idx_q;
  logic             accept;
  logic             max_gt;
  logic             min_ls;
  logic             max_eq_unused;
  logic             max_ls_unused;
  logic             min_gt_unused;
  logic             min_eq_unused;

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid & in_ready;

  N_bit_comp #(.N(N)) u_cmp_max (
    .A  (in_data),
    .B  (max_q),
    .gt (max_gt),
    .eq (max_eq_unused),
    .ls (max_ls_unused)
  );

  N_bit_comp #(.N(N)) u_cmp_min (
    .A  (in_data),
    .B  (min_q),
    .gt (min_gt_unused),
    .eq (min_eq_unused),
    .ls (min_ls)
  );

  // Running extremes double as the output registers; they only matter while out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      count_q   <= '0;
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
    end else if (clear) begin
      state_q <= COLLECT;
      count_q <= '0;
    end else if (state_q == COLLECT) begin
      if (accept) begin
        if (count_q == '0) begin
          max_q     <= in_data;
          min_q     <= in_data;
          max_idx_q <= '0;
          min_idx_q <= '0;
        end else begin
          // Strict compares keep the first occurrence on ties.
          if (max_gt) begin
            max_q     <= in_data;
            max_idx_q <= count_q;
          end
          if (min_ls) begin
            min_q     <= in_data;
            min_idx_q <= count_q;
          end
        end
        if (count_q == LAST_IDX) begin
          state_q <= HOLD;
          count_q <= '0;
        end else begin
          count_q <= count_q + IDX_W'(1);
        end
      end
    end else if (out_ready) begin
      state_q <= COLLECT;
    end
  end

  assign out_max     = max_q;
  assign out_min     = min_q;
  assign out_max_idx = max_idx_q;
  assign out_min_idx = min_idx_q;

endmodule
